// File: rtl/led_event_sched_if.sv
// Purpose : bundles the IR-decoder event levels and the LED scheduler status
//           outputs into one port so the top level wires a single bus.
// Latency : none (wires only). Backpressure: none; events are level inputs.
// Ports   : req[2:0]  event levels (bit2 error, bit1 frame, bit0 repeat)
//           led_n     LED drive, active-low
//           busy      burst in progress
//           grant     one-hot source being served, 0 when idle
//           done      one-cycle pulse when a burst completes
interface led_event_sched_if;
    logic [2:0] req;
    logic       led_n;
    logic       busy;
    logic [2:0] grant;
    logic       done;

    // Scheduler side: consumes events, drives LED and status.
    modport slave (
        input  req,
        output led_n,
        output busy,
        output grant,
        output done
    );

    // Decoder / top-level side: produces events, observes LED and status.
    modport master (
        output req,
        input  led_n,
        input  busy,
        input  grant,
        input  done
    );
endinterface : led_event_sched_if

// File: rtl/led_event_sched.sv
// Purpose : shares one LED between three IR event sources, showing each event
//           as a source-specific burst of blinks (error 3, frame 2, repeat 1).
// Latency : req rising before edge k -> LED lit from edge k+2 when idle.
// Backpr. : none; events arriving while busy are held as pending bits and
//           repeated events of one source collapse into a single replay.
// Ports   : sys_clk / sys_rst (async, active-high) plain ports;
//           bus (slave modport): req in, led_n/busy/grant/done out.
module led_event_sched #(
    parameter int ON_CNT  = 2_500_000,
    parameter int GAP_CNT = 2_500_000,
    parameter int CNT_W   = 22,
    parameter int BLINK0  = 1,
    parameter int BLINK1  = 2,
    parameter int BLINK2  = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    led_event_sched_if.slave    bus
);

    localparam int BLK_MAX = (BLINK2 > BLINK1) ? ((BLINK2 > BLINK0) ? BLINK2 : BLINK0)
                                               : ((BLINK1 > BLINK0) ? BLINK1 : BLINK0);
    localparam int BLK_W   = (BLK_MAX < 1) ? 1 : $clog2(BLK_MAX + 1);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       pend_q,  pend_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic [2:0]       grant_q, grant_d;
    logic             led_n_q, led_n_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Combinational helpers
    logic [2:0]       rise;
    logic [2:0]       arb;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = bus.req;
        sync2_d = sync1_q;
        rise    = sync1_q & ~sync2_q;

        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        grant_d = grant_q;
        arb     = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    // Fixed priority: error > frame > repeat.
                    if (pend_q[2]) begin
                        arb     = 3'b100;
                        blink_d = BLK_W'(BLINK2);
                    end else if (pend_q[1]) begin
                        arb     = 3'b010;
                        blink_d = BLK_W'(BLINK1);
                    end else begin
                        arb     = 3'b001;
                        blink_d = BLK_W'(BLINK0);
                    end
                    grant_d = arb;
                    timer_d = ON_LOAD;
                    state_d = S_ON;
                end
            end

            S_ON: begin
                if (timer_q == '0) begin
                    // Blink is counted as consumed when its lit phase ends.
                    timer_d = GAP_LOAD;
                    blink_d = blink_q - BLK_ONE;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
            end

            S_GAP: begin
                if (timer_q == '0) begin
                    if (blink_q != '0) begin
                        timer_d = ON_LOAD;
                        state_d = S_ON;
                    end else begin
                        // Grant drops on the same edge that raises done.
                        grant_d = 3'b000;
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
            end

            S_DONE: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end

            default: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
        endcase

        // A rise coinciding with its own grant keeps the bit set, so an event
        // that lands on the grant edge is replayed instead of being lost.
        pend_d = (pend_q & ~arb) | rise;

        // Outputs are registered from the next state so they change on the
        // same edge as the state they describe.
        led_n_d = (state_d != S_ON);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            pend_q  <= 3'b000;
            state_q <= S_IDLE;
            timer_q <= '0;
            blink_q <= '0;
            grant_q <= 3'b000;
            led_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            grant_q <= grant_d;
            led_n_q <= led_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.led_n = led_n_q;
    assign bus.busy  = busy_q;
    assign bus.grant = grant_q;
    assign bus.done  = done_q;

endmodule : led_event_sched

// File: doc/led_event_sched.md
Name: led_event_sched

Overview:
- Shares the single board LED between three infrared-receiver event sources: repeat code, new valid frame, frame/check error.
- Each event is synchronised and rising-edge detected, then latched as pending.
- Pending events are served one at a time in fixed priority. Each is shown as a source-specific burst of N blinks, so the user can tell events apart.
- Sits in the top level between the IR decoder flags and the LED pin, replacing a direct single-pulse LED driver.

Parameters:
- ON_CNT, 2_500_000, clocks LED is lit per blink (0.05 s at 50 MHz).
- GAP_CNT, 2_500_000, clocks LED is dark after each blink, including after the last blink of a burst.
- CNT_W, 22, timer width; must hold max(ON_CNT, GAP_CNT).
- BLINK0, 1, blinks for req[0] (repeat).
- BLINK1, 2, blinks for req[1] (new frame).
- BLINK2, 3, blinks for req[2] (error).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- req  in  3  event levels from decoder, asynchronous to sys_clk; bit2 = error, bit1 = frame, bit0 = repeat.
- led_n  out  1  LED drive, active-low (0 = lit).
- busy  out  1  high while a burst is in progress (FSM not IDLE).
- grant  out  3  one-hot source currently being served; 0 when idle.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- One clock domain (sys_clk); reset is asynchronous and active-high (sys_rst).
- Reset values: led_n=1, busy=0, grant=0, done=0. Sync flops, pending, timer, blink counter and FSM (IDLE) all clear.
- Reset asserted mid-burst aborts the burst immediately: LED dark, pending lost.
- Input sync: two flops per bit (d1, d2). rise[i] = d1[i] & ~d2[i].
- Pending: pend[i] sets on edge after rise[i]=1. It clears on the edge where source i is granted.
- If rise[i] and grant of i coincide, pend[i] stays set (new event not lost).
- A re-trigger of the source being served sets pend again, so it is replayed once after the current burst. Multiple re-triggers collapse into one.
- Arbitration happens only in IDLE. Fixed priority: bit2 > bit1 > bit0.
- FSM states: IDLE, ON, GAP, DONE.
  - IDLE: if any pend, grant the highest-priority source; load blink counter with its BLINKx and timer with ON_CNT-1; go to ON.
  - ON: led_n=0. Timer decrements each cycle. At 0: load GAP_CNT-1, decrement blink counter, go to GAP.
  - GAP: led_n=1. At timer 0: if blink counter > 0, load ON_CNT-1 and go to ON; else go to DONE.
  - DONE: done=1 for one cycle, grant cleared, go to IDLE.
  - IDLE→ON can occur on the edge after DONE, giving back-to-back bursts.
- led_n, busy, grant and done are registered, updated on the same edge as the state they reflect.
  - Each blink: exactly ON_CNT cycles low, then GAP_CNT cycles high.
- Latency: req rising before edge k gives d1=1 at k, pend=1 at k+1, and led_n=0, busy=1 from edge k+2 (when IDLE).
- Lower-priority pend is held, never dropped, while a higher source is served. Starvation of bit0 under continuous bit2 is accepted.
- Timer arithmetic is unsigned CNT_W; it never wraps. A load always takes precedence over a decrement.
- ON_CNT=1 or GAP_CNT=1 is legal: a one-cycle phase.

Test Plan (bench uses ON_CNT=4, GAP_CNT=3):
- Reset, then req=0 for 20 cycles → led_n=1, busy=0, grant=000, done never pulses.
- req[0] rises at edge 10 → led_n=0 for edges 12–15, high 16–18; done=1 at edge 19; grant=001 during 12–18.
- req=3'b111 in the same cycle → bursts served in order error (3 blinks), frame (2), repeat (1). Total led_n low cycles = 24. Three done pulses, grant sequence 100, 010, 001.
- req[1] during a req[0] burst's ON phase → req[0] burst completes unaltered; frame burst (2 blinks) starts the edge after done.
- req[2] re-toggled twice during its own burst → exactly one additional 3-blink burst follows, then IDLE.
- sys_rst asserted mid-ON of a req[2] burst → led_n=1, busy=0, grant=000 immediately (asynchronous). After release with req=0 no blinks occur, since pending was cleared.
